uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. Captures each completed character (data byte plus its framing/parity error flag) on the receiver's one-cycle completion strobe, holds it in a first-word-fall-through FIFO, and presents it to the host read port. Also provides overflow tracking, RTS flow control and an idle-timeout interrupt for partially filled buffers.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries.
- TIMEOUT_WIDTH, 16: width of the idle-timeout counter and its compare input.

- clk  in  1  system clock
- resetb  in  1  reset, asynchronous, active-low
- rx_re  in  1  one-cycle strobe from the receiver: a character has completed
- rx_error  in  1  error flag qualified by rx_re (that character failed framing/parity)
- rx_data  in  8  received byte, qualified by rx_re
- rx_busy  in  1  receiver is mid-character
- rd  in  1  host read strobe; pops the head entry
- rd_data  out  8  head entry data (FWFT, valid while !empty)
- rd_err  out  1  head entry error flag (valid while !empty)
- empty  out  1  FIFO holds no entries
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries
- level  out  DEPTH_LOG2+1  entry count, 0..2^DEPTH_LOG2
- overflow  out  1  sticky: a character was dropped because the FIFO was full
- clear_overflow  in  1  clears overflow
- flush  in  1  synchronous empty of the FIFO
- rts_threshold  in  DEPTH_LOG2+1  level at or above which rts_n deasserts
- rts_n  out  1  active-low request-to-send toward the remote transmitter
- timeout_cycles  in  TIMEOUT_WIDTH  idle cycles before timeout; 0 disables
- timeout  out  1  one-cycle pulse: data is waiting and the line has gone idle

## Operation
- Each entry is 9 bits {err, data}. Write occurs on an rx_re cycle. Pop occurs on a rd cycle with !empty.
- rd while empty is ignored and has no side effects.
- rx_re while full and no rd in the same cycle drops the character and sets overflow.
- rx_re and rd in the same cycle while full: both are performed, and level is unchanged.
- rx_re and rd in the same cycle while empty: write only.
- Pointers are DEPTH_LOG2 bits and wrap naturally. level is maintained as a separate counter of width DEPTH_LOG2+1.
- empty = (level==0). full = (level==2^DEPTH_LOG2). Both are derived from the registered level.
- flush has the highest priority. It zeroes the pointers and level and ignores the same-cycle rx_re and rd. It does not clear overflow.
- overflow: set has priority over clear_overflow in the same cycle. It is cleared only by clear_overflow or by reset.
- rts_n is a register equal to (level_next >= rts_threshold). With rts_threshold==0, rts_n is held at 1.
- Timeout counter:
  - Cleared on any write, any pop, flush, empty, or rx_busy=1.
  - Otherwise increments, saturating.
  - timeout pulses for one cycle when the counter equals timeout_cycles-1 and timeout_cycles!=0.
  - At most one pulse per idle period; a re-arm requires a clearing event.

## Timing
- Reset values: empty=1, full=0, level=0, overflow=0, rts_n=0 (or 1 if rts_threshold==0 after the first clock), timeout=0, rd_data=0, rd_err=0.
- Write latency: an rx_re in cycle N is visible at rd_data, with empty=0 and level updated, in cycle N+1.
- rd in cycle N: the next head entry, or empty=1, appears in cycle N+1. rd_data is combinational from the storage array at the read pointer.
- overflow is set in cycle N+1 after a dropped rx_re in cycle N.
- Asynchronous reset mid-operation discards all contents immediately.
- timeout asserts exactly timeout_cycles cycles after the last clearing event.

## Structure
- The shared package uart_pkg holds UART_ENTRY_W=9 and the entry field positions (ERR_BIT=8, DATA_MSB=7). The receiver and transmitter blocks use the same package.
- One sub-module, uart_fifo_ram: a 2^DEPTH_LOG2 x 9 register array with a synchronous write port and an asynchronous read port. No reset on storage.
- Pointer, level, overflow, RTS and timeout logic live in uart_rx_fifo.

## Test plan
- Write 0x41, 0x42 (err=0), then 0x43 with rx_error=1, then read three times. Expect rd_data 0x41/0x42/0x43, rd_err 0/0/1, level 3→0, empty=1 after the last pop.
- DEPTH_LOG2=4: write 17 bytes 0x00..0x10. Expect full=1 after 16 writes, overflow=1 after the 17th, and reads return 0x00..0x0F. Pulse clear_overflow → overflow=0.
- Fill to full, then assert rx_re=1 with 0x55 and rd=1 in the same cycle. Expect no overflow, level remains 16, and the tail after draining is 0x55.
- rts_threshold=12: write 12 bytes → rts_n=1 on the cycle after the 12th write. Read one → rts_n=0.
- timeout_cycles=100: write one byte, hold rx_busy=0 → timeout pulses exactly once, 100 cycles later. Repeat with rx_busy held high → no pulse. timeout_cycles=0 → never pulses.
- Load 5 bytes, then assert flush together with rx_re → level=0, empty=1, and overflow unchanged. Assert resetb=0 mid-burst → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART entry layout used by the receive, transmit and buffer blocks
package uart_pkg;
    localparam int UART_ENTRY_W = 9;
    localparam int ERR_BIT      = 8;
    localparam int DATA_MSB     = 7;

    typedef logic [UART_ENTRY_W-1:0] uart_entry_t;

    function automatic uart_entry_t pack_entry(input logic err, input logic [DATA_MSB:0] data);
        return {err, data};
    endfunction
endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: unreset register array, synchronous write, asynchronous read
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [UART_ENTRY_W-1:0] wdata,
    input  logic [ADDR_W-1:0]       raddr,
    output logic [UART_ENTRY_W-1:0] rdata
);
    logic [UART_ENTRY_W-1:0] mem [2**ADDR_W];

    // storage write; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive buffer with overflow, RTS flow control and idle timeout
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2    = 4,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     rx_re,
    input  logic                     rx_error,
    input  logic [7:0]               rx_data,
    input  logic                     rx_busy,
    input  logic                     rd,
    output logic [7:0]               rd_data,
    output logic                     rd_err,
    output logic                     empty,
    output logic                     full,
    output logic [DEPTH_LOG2:0]      level,
    output logic                     overflow,
    input  logic                     clear_overflow,
    input  logic                     flush,
    input  logic [DEPTH_LOG2:0]      rts_threshold,
    output logic                     rts_n,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    output logic                     timeout
);
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

    logic [DEPTH_LOG2-1:0]    wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]      level_next;
    logic [TIMEOUT_WIDTH-1:0] idle_cnt, idle_cnt_next;
    logic [UART_ENTRY_W-1:0]  head;
    logic                     do_wr, do_pop, drop, idle_clr;

    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);

    // flush swallows both ports; a full write only lands if a pop frees a slot
    always_comb begin
        do_pop        = !flush && rd && !empty;
        do_wr         = !flush && rx_re && (!full || do_pop);
        drop          = !flush && rx_re && full && !do_pop;
        level_next    = flush ? '0 : level + (DEPTH_LOG2+1)'(do_wr) - (DEPTH_LOG2+1)'(do_pop);
        idle_clr      = do_wr || do_pop || flush || empty || rx_busy;
        idle_cnt_next = idle_clr ? '0 : (&idle_cnt) ? idle_cnt : idle_cnt + TIMEOUT_WIDTH'(1);
    end

    uart_fifo_ram #(.ADDR_W(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata (pack_entry(rx_error, rx_data)),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // head is forced to zero while empty so stale storage never leaks out
    assign rd_data = empty ? '0 : head[DATA_MSB:0];
    assign rd_err  = !empty && head[ERR_BIT];

    // pointers and occupancy
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= flush ? '0 : do_wr ? wr_ptr + DEPTH_LOG2'(1) : wr_ptr;
            rd_ptr <= flush ? '0 : do_pop ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
            level  <= level_next;
        end
    end

    // sticky overflow; a drop wins over a same-cycle clear
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) overflow <= 1'b0;
        else         overflow <= drop ? 1'b1 : clear_overflow ? 1'b0 : overflow;
    end

    // registered flow control from the upcoming occupancy
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) rts_n <= 1'b0;
        else         rts_n <= (level_next >= rts_threshold);
    end

    // idle cycles since the last write, pop, flush, empty or busy cycle
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) idle_cnt <= '0;
        else         idle_cnt <= idle_cnt_next;
    end

    assign timeout = (timeout_cycles != '0) && (idle_cnt == timeout_cycles - TIMEOUT_WIDTH'(1))
                     && !empty && !rx_busy;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: queue-model scoreboard plus directed literal checks for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, resetb = 1'b1;
    logic        rx_re = 1'b0, rx_error = 1'b0, rx_busy = 1'b0, rd = 1'b0;
    logic        clear_overflow = 1'b0, flush = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [4:0]  rts_threshold = 5'd0;
    logic [15:0] timeout_cycles = 16'd0;
    logic [7:0]  rd_data;
    logic        rd_err, empty, full, overflow, rts_n, timeout;
    logic [4:0]  level;

    int n_tests = 0, n_fail = 0;
    logic [8:0] q[$];
    bit m_ov = 0, m_rts = 0;
    int m_idle = 0;

    uart_rx_fifo dut (
        .clk(clk), .resetb(resetb), .rx_re(rx_re), .rx_error(rx_error), .rx_data(rx_data),
        .rx_busy(rx_busy), .rd(rd), .rd_data(rd_data), .rd_err(rd_err), .empty(empty),
        .full(full), .level(level), .overflow(overflow), .clear_overflow(clear_overflow),
        .flush(flush), .rts_threshold(rts_threshold), .rts_n(rts_n),
        .timeout_cycles(timeout_cycles), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: FIFO as a queue, overflow flag, cycles since last clearing event
    task automatic model_step();
        int  sz;
        bit  pop, wr, drop, clr;
        if (!resetb) begin
            q.delete();
            m_ov = 0; m_rts = 0; m_idle = 0;
        end else begin
            sz   = q.size();
            pop  = !flush && rd && sz > 0;
            wr   = !flush && rx_re && (sz < DEPTH || pop);
            drop = !flush && rx_re && sz == DEPTH && !pop;
            clr  = flush || wr || pop || sz == 0 || rx_busy;
            if (flush) q.delete();
            if (pop) void'(q.pop_front());
            if (wr) q.push_back({rx_error, rx_data});
            m_ov   = drop ? 1'b1 : clear_overflow ? 1'b0 : m_ov;
            m_rts  = q.size() >= int'(rts_threshold);
            m_idle = clr ? 0 : m_idle + 1;
        end
    endtask

    task automatic compare();
        int sz = q.size();
        chk("level", level, sz);
        chk("empty", empty, sz == 0);
        chk("full", full, sz == DEPTH);
        chk("overflow", overflow, m_ov);
        chk("rts_n", rts_n, m_rts);
        chk("rd_data", rd_data, sz > 0 ? q[0][7:0] : 8'h00);
        chk("rd_err", rd_err, sz > 0 ? q[0][8] : 1'b0);
        chk("timeout", timeout, timeout_cycles != 0 && m_idle == int'(timeout_cycles) - 1
                                && sz > 0 && !rx_busy);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] b, input logic e);
        rx_re = 1'b1; rx_data = b; rx_error = e;
        cyc();
        rx_re = 1'b0; rx_error = 1'b0;
    endtask

    task automatic read();
        rd = 1'b1;
        cyc();
        rd = 1'b0;
    endtask

    task automatic count_pulses(input int n, output int pulses, output int at);
        pulses = 0; at = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (timeout) begin pulses++; at = i; end
        end
    endtask

    initial begin
        int pulses, at;
        fork
            forever begin @(posedge clk or negedge resetb); model_step(); end
            forever begin @(negedge clk); compare(); end
        join_none
        #2 resetb = 1'b0;
        @(negedge clk);
        chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_level", level, 0);
        chk("rst_rts", rts_n, 0); chk("rst_data", rd_data, 0); chk("rst_to", timeout, 0);
        @(posedge clk); #1 resetb = 1'b1;
        cyc(); @(negedge clk);
        chk("rts_thr0", rts_n, 1);

        write(8'h41, 0); write(8'h42, 0); write(8'h43, 1);
        @(negedge clk); chk("t1_level3", level, 3); chk("t1_d0", rd_data, 8'h41); chk("t1_e0", rd_err, 0);
        read(); @(negedge clk); chk("t1_d1", rd_data, 8'h42); chk("t1_level2", level, 2);
        read(); @(negedge clk); chk("t1_d2", rd_data, 8'h43); chk("t1_e2", rd_err, 1);
        read(); @(negedge clk); chk("t1_empty", empty, 1); chk("t1_level0", level, 0);

        for (int i = 0; i < 16; i++) write(8'(i), 0);
        @(negedge clk); chk("t2_full", full, 1); chk("t2_ov0", overflow, 0);
        write(8'h10, 0);
        @(negedge clk); chk("t2_ov1", overflow, 1); chk("t2_level16", level, 16);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); chk("t2_drain", rd_data, i);
            read();
        end
        @(negedge clk); chk("t2_empty", empty, 1);
        clear_overflow = 1'b1; cyc(); clear_overflow = 1'b0;
        @(negedge clk); chk("t2_clr", overflow, 0);

        for (int i = 0; i < 16; i++) write(8'(8'h60 + i), 0);
        rx_re = 1'b1; rx_data = 8'h55; rd = 1'b1; cyc(); rx_re = 1'b0; rd = 1'b0;
        @(negedge clk); chk("t3_level", level, 16); chk("t3_ov", overflow, 0); chk("t3_head", rd_data, 8'h61);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); chk("t3_drain", rd_data, i == 15 ? 8'h55 : 8'(8'h61 + i));
            read();
        end

        rts_threshold = 5'd12;
        for (int i = 0; i < 11; i++) write(8'(i), 0);
        @(negedge clk); chk("t4_rts11", rts_n, 0);
        write(8'h0B, 0);
        @(negedge clk); chk("t4_rts12", rts_n, 1);
        read(); @(negedge clk); chk("t4_rts_rd", rts_n, 0);
        for (int i = 0; i < 11; i++) read();

        timeout_cycles = 16'd100;
        write(8'hA5, 0);
        count_pulses(150, pulses, at);
        chk("t5_pulses", pulses, 1); chk("t5_at", at, 100);
        read();
        rx_busy = 1'b1;
        write(8'hA6, 0);
        count_pulses(150, pulses, at);
        chk("t5_busy", pulses, 0);
        read(); rx_busy = 1'b0;
        timeout_cycles = 16'd0;
        write(8'hA7, 0);
        count_pulses(150, pulses, at);
        chk("t5_off", pulses, 0);
        read();

        for (int i = 0; i < 5; i++) write(8'(8'h70 + i), 0);
        @(negedge clk); chk("t6_level5", level, 5);
        flush = 1'b1; rx_re = 1'b1; rx_data = 8'hAA; cyc(); flush = 1'b0; rx_re = 1'b0;
        @(negedge clk); chk("t6_level0", level, 0); chk("t6_empty", empty, 1); chk("t6_ov", overflow, 0);
        for (int i = 0; i < 17; i++) write(8'(8'h80 + i), 0);
        flush = 1'b1; rx_re = 1'b1; rd = 1'b1; cyc(); flush = 1'b0; rx_re = 1'b0; rd = 1'b0;
        @(negedge clk); chk("t6_keep_ov", overflow, 1); chk("t6_fl_level", level, 0);

        for (int i = 0; i < 3; i++) write(8'(8'h90 + i), 0);
        rx_re = 1'b1; rx_data = 8'h93;
        @(posedge clk); #3 resetb = 1'b0; #1;
        chk("r_empty", empty, 1); chk("r_full", full, 0); chk("r_level", level, 0);
        chk("r_ov", overflow, 0); chk("r_rts", rts_n, 0); chk("r_to", timeout, 0);
        chk("r_data", rd_data, 0); chk("r_err", rd_err, 0);
        rx_re = 1'b0;
        @(posedge clk); #1 resetb = 1'b1;
        write(8'h99, 1);
        @(negedge clk); chk("r_after", rd_data, 8'h99); chk("r_after_lv", level, 1);
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
